ultrasonic_controller: RTL and testbench
========================================

Name: ultrasonic_controller

Overview:
Drives an HC-SR04-style ultrasonic ranger and reports the measured distance in centimetres. The block waits a fixed idle period, then issues a 10 us trigger pulse. It times the width of the returned echo pulse in microseconds and converts that width to whole centimetres at 58 us/cm. It sits between the sensor pins and the system control logic, and runs from a single 100 MHz clock.

Parameters:
CLKS_PER_US, 100, clock cycles per microsecond tick (100 MHz clock)
IDLE_US, 500000, idle interval before each trigger (500 ms)
TRIG_US, 10, trigger pulse width in us
US_PER_CM, 58, echo microseconds per centimetre (round trip)
TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo high time
MAX_CM, 1023, saturation value of distance

Ports:
clk  input  1  system clock, 100 MHz, rising edge
reset  input  1  asynchronous, active-high reset
trig  output  1  trigger pulse to the sensor; registered output
echo  input  1  echo pulse from the sensor; asynchronous to clk
distance  output  10  last valid measurement in cm; registered output

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, trig=0, distance=0.
  - All counters cleared; echo synchronizer cleared to 0.
  - Reset mid-operation aborts any measurement immediately.
- echo input:
  - Passes through a 2-flop synchronizer.
  - Rising and falling edges are detected on the synchronized signal.
- Microsecond tick:
  - A prescaler counts 0..CLKS_PER_US-1 and pulses tick for one cycle at wrap.
  - The prescaler restarts at 0 on every state entry.
- IDLE:
  - trig=0.
  - Count IDLE_US ticks, then go to TRIG.
- TRIG:
  - trig=1 for exactly TRIG_US*CLKS_PER_US cycles (1000 cycles = 10 us), then trig=0 and go to WAIT_ECHO.
- WAIT_ECHO:
  - On a synchronized echo rising edge, clear us_sub=0 and cm=0, then go to MEASURE.
  - If TIMEOUT_US ticks elapse without a rise, go to IDLE with distance unchanged.
  - An echo that is already high on entry is ignored until a fresh rising edge occurs.
- MEASURE (counting is division-free):
  - On each tick, increment us_sub.
  - When us_sub reaches US_PER_CM-1, set us_sub=0 and increment cm.
  - cm saturates at MAX_CM.
  - On a synchronized echo falling edge, go to DONE.
  - If echo stays high for TIMEOUT_US ticks, load distance=MAX_CM and go to IDLE.
- DONE:
  - One cycle; distance <= cm (floor of echo_us/58), then go to IDLE.
  - distance is valid no more than 5 clock cycles (50 ns) after echo falls at the pin.
- distance holds its value between measurements; it only changes in DONE, on echo timeout, or on reset.
- Measurement repeats continuously: IDLE -> TRIG -> WAIT_ECHO -> MEASURE -> DONE -> IDLE.
- Any partial microsecond at the echo fall is discarded (truncation).

Test Plan:
- Reset then release, echo=0 -> trig=0 and distance=0 during reset; first trig rise at IDLE_US after release (500 ms default; the bench may override IDLE_US=1000 for speed).
- Trigger width -> trig high for exactly 1000 clk cycles (10 us), then low.
- Echo raised 100 ns after trig falls and held 584 us -> distance=10 within 100 ns of echo fall.
- Echo widths of 57 us, 58 us and 115 us in successive cycles -> distance=0, 1 and 1 respectively; the value is held between cycles.
- No echo after trig -> after 30 ms returns to IDLE, distance keeps its previous value, and the next trig occurs after another IDLE_US.
- Echo stuck high beyond 30 ms -> distance=1023; assert reset mid-MEASURE -> trig=0, distance=0 immediately.

Source files
------------

// File: rtl/ultrasonic_controller.sv
// HC-SR04-style ranger: periodic trigger, echo pulse timing in microseconds,
// division-free conversion to whole centimetres with saturation and timeouts.
module ultrasonic_controller #(
    parameter int CLKS_PER_US = 100,
    parameter int IDLE_US     = 500000,
    parameter int TRIG_US     = 10,
    parameter int US_PER_CM   = 58,
    parameter int TIMEOUT_US  = 30000,
    parameter int MAX_CM      = 1023
) (
    input  logic       clk,
    input  logic       reset,
    output logic       trig,
    input  logic       echo,
    output logic [9:0] distance
);

    localparam int CNT_MAX0 = (IDLE_US > TIMEOUT_US) ? IDLE_US : TIMEOUT_US;
    localparam int CNT_MAX  = (CNT_MAX0 > TRIG_US) ? CNT_MAX0 : TRIG_US;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int PRE_W    = $clog2(CLKS_PER_US + 1);
    localparam int SUB_W    = $clog2(US_PER_CM + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLKS_PER_US - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_US - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_US - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(US_PER_CM - 1);
    localparam logic [9:0]       CM_MAX    = 10'(MAX_CM);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE} state_t;

    state_t           state;
    logic             echo_p0, echo_p1, echo_p2;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] us_cnt;
    logic [SUB_W-1:0] us_sub;
    logic [9:0]       cm;
    logic             tick, rise, fall;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v >= CM_MAX) ? CM_MAX : v + 10'd1;
    endfunction

    assign tick = (pre == PRE_LAST);
    assign rise = echo_p1 & ~echo_p2;
    assign fall = ~echo_p1 & echo_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            trig     <= 1'b0;
            distance <= '0;
            echo_p0  <= 1'b0;
            echo_p1  <= 1'b0;
            echo_p2  <= 1'b0;
            pre      <= '0;
            us_cnt   <= '0;
            us_sub   <= '0;
            cm       <= '0;
        end else begin
            // p0/p1 resynchronise the pin, p2 holds the previous level for edges
            echo_p0 <= echo;
            echo_p1 <= echo_p0;
            echo_p2 <= echo_p1;

            // Free-running microsecond base; every state change below restarts it
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                us_cnt <= us_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (tick && us_cnt == IDLE_LAST) begin
                        state  <= TRIG;
                        trig   <= 1'b1;
                        pre    <= '0;
                        us_cnt <= '0;
                    end
                end
                TRIG: begin
                    if (tick && us_cnt == TRIG_LAST) begin
                        state  <= WAIT_ECHO;
                        trig   <= 1'b0;
                        pre    <= '0;
                        us_cnt <= '0;
                    end
                end
                WAIT_ECHO: begin
                    if (rise) begin
                        state  <= MEASURE;
                        us_sub <= '0;
                        cm     <= '0;
                        pre    <= '0;
                        us_cnt <= '0;
                    end else if (tick && us_cnt == TO_LAST) begin
                        state  <= IDLE;
                        pre    <= '0;
                        us_cnt <= '0;
                    end
                end
                MEASURE: begin
                    // A tick coinciding with the fall still counts as a full microsecond
                    if (tick) begin
                        if (us_sub == SUB_LAST) begin
                            us_sub <= '0;
                            cm     <= sat_inc(cm);
                        end else begin
                            us_sub <= us_sub + 1'b1;
                        end
                    end
                    if (fall) begin
                        state  <= DONE;
                        pre    <= '0;
                        us_cnt <= '0;
                    end else if (tick && us_cnt == TO_LAST) begin
                        state    <= IDLE;
                        distance <= CM_MAX;
                        pre      <= '0;
                        us_cnt   <= '0;
                    end
                end
                DONE: begin
                    distance <= cm;
                    state    <= IDLE;
                    pre      <= '0;
                    us_cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    trig  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_controller.sv
// Directed bench for ultrasonic_controller with shortened idle/timeout
// intervals and a 4-clock microsecond so whole measurement cycles fit.
module tb_ultrasonic_controller;

    localparam int C        = 4;
    localparam int IDLE     = 20;
    localparam int TRIGU    = 10;
    localparam int UPC      = 58;
    localparam int TO       = 1000;
    localparam int IDLE_CYC = IDLE * C;
    localparam int TRIG_CYC = TRIGU * C;
    localparam int TO_CYC   = TO * C;

    typedef struct {
        int echo_us;
        int exp_cm;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       trig;
    logic       echo;
    logic [9:0] distance;
    int         total = 0;
    int         bad = 0;
    vec_t       vecs[6];

    ultrasonic_controller #(
        .CLKS_PER_US(C),
        .IDLE_US(IDLE),
        .TRIG_US(TRIGU),
        .US_PER_CM(UPC),
        .TIMEOUT_US(TO),
        .MAX_CM(1023)
    ) dut (
        .clk(clk),
        .reset(reset),
        .trig(trig),
        .echo(echo),
        .distance(distance)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts clock edges until trig reaches lvl; -1 when the budget runs out.
    task automatic wait_trig(input logic lvl, input int budget, output int n);
        n = 0;
        while (trig !== lvl) begin
            if (n >= budget) begin
                n = -1;
                return;
            end
            step(1);
            n++;
        end
    endtask

    task automatic do_trig(input string tag, output int rise_n);
        int w;
        wait_trig(1'b1, 20000, rise_n);
        wait_trig(1'b0, 2000, w);
        chk({tag, " trig width"}, w, TRIG_CYC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        int w;
        int prev;

        vecs[0] = '{584, 10};
        vecs[1] = '{57, 0};
        vecs[2] = '{1, 0};
        vecs[3] = '{58, 1};
        vecs[4] = '{115, 1};
        vecs[5] = '{116, 2};

        reset = 1'b1;
        echo  = 1'b0;
        step(3);
        chk("reset trig", int'(trig), 0);
        chk("reset distance", int'(distance), 0);
        reset = 1'b0;

        do_trig("first", n);
        chk("first trig latency", n, IDLE_CYC);

        prev = 0;
        for (int i = 0; i < 6; i++) begin
            step(10);
            echo = 1'b1;
            step(vecs[i].echo_us * C);
            chk($sformatf("v%0d held during echo", i), int'(distance), prev);
            echo = 1'b0;
            step(5);
            chk($sformatf("v%0d distance %0dus", i, vecs[i].echo_us), int'(distance), vecs[i].exp_cm);
            prev = vecs[i].exp_cm;
            do_trig($sformatf("v%0d next", i), n);
            chk($sformatf("v%0d held at next trig", i), int'(distance), prev);
        end

        // No echo at all: wait timeout, then a full idle before the next trigger
        wait_trig(1'b1, 20000, n);
        chk("no-echo retrigger", n, TO_CYC + IDLE_CYC);
        chk("no-echo distance", int'(distance), 2);

        // Echo already high when WAIT_ECHO is entered must not start a measurement
        echo = 1'b1;
        wait_trig(1'b0, 2000, w);
        chk("pre-high trig width", w, TRIG_CYC);
        wait_trig(1'b1, 20000, n);
        chk("pre-high retrigger", n, TO_CYC + IDLE_CYC);
        chk("pre-high distance", int'(distance), 2);
        echo = 1'b0;
        wait_trig(1'b0, 2000, w);
        chk("pre-high next trig width", w, TRIG_CYC);

        // Echo stuck high: distance saturates to MAX_CM on the echo timeout
        step(10);
        echo = 1'b1;
        step(3 + TO_CYC - 8);
        chk("stuck before timeout", int'(distance), 2);
        step(20);
        chk("stuck timeout distance", int'(distance), 1023);
        echo = 1'b0;
        do_trig("post-timeout", n);
        chk("post-timeout trig latency", n, IDLE_CYC - 12);

        // Reset in the middle of a measurement
        step(10);
        echo = 1'b1;
        step(100);
        reset = 1'b1;
        #1;
        chk("mid-measure reset trig", int'(trig), 0);
        chk("mid-measure reset distance", int'(distance), 0);
        echo = 1'b0;
        step(2);
        reset = 1'b0;
        do_trig("after reset", n);
        chk("after reset trig latency", n, IDLE_CYC);
        chk("after reset distance", int'(distance), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
